// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter slice.
//   DIGIT_W      : width of one decimal digit (nibble)
//   BCD_MAX/MIN  : legal digit range
//   sanitize_bcd : clamps a raw nibble into the legal BCD range
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  // Any nibble above 9 (A..F) is forced to 9 so Q never leaves BCD.
  function automatic logic [DIGIT_W-1:0] sanitize_bcd(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal decade register with preload and up/down stepping.
// Ports:
//   Clock     : system clock, rising edge
//   Resetn    : asynchronous active-low reset, clears q
//   load      : synchronous preload strobe (priority over step_in)
//   d         : preload nibble, sanitised to 0..9 on load
//   step_in   : advance this digit by one in direction 'up'
//   up        : 1 = increment, 0 = decrement
//   q         : current digit value, always 0..9
//   carry_out : combinational; this digit wraps on the current step
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               step_in,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= sanitize_bcd(d);
    end else if (step_in) begin
      if (up) begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

  // Ripple into the next decade only when this one is about to wrap.
  assign carry_out = step_in & (up ? (q == BCD_MAX) : (q == BCD_MIN));

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit decimal up/down counter paced by an internal prescaler.
// Ports:
//   Clock   : system clock, rising edge
//   Resetn  : asynchronous active-low reset (Q, prescaler, Step, Carry -> 0)
//   En      : enables the prescaler and count steps; 0 holds everything
//   Up      : count direction, 1 = up, sampled on the step cycle
//   Load    : synchronous preload, overrides stepping, clears prescaler
//   LoadVal : preload value, nibble 0 = least-significant digit
//   Q       : current count in BCD, nibble 0 = least-significant digit
//   Step    : one-cycle pulse in the cycle Q shows a count step
//   Carry   : one-cycle pulse on full wrap (all-9s <-> 0)
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      En,
  input  logic                      Up,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] LoadVal,
  output logic [DIGIT_W*DIGITS-1:0] Q,
  output logic                      Step,
  output logic                      Carry
);

  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick_p0;
  logic             step_go_p0;
  logic [DIGITS:0]  chain_p0;
  logic             step_p1;
  logic             carry_p1;

  // Stage p0: prescaler and step decision
  assign tick_p0    = En & (pre_cnt == TICK_LAST);
  assign step_go_p0 = tick_p0 & ~Load;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pre_cnt <= '0;
    end else if (Load) begin
      pre_cnt <= '0;
    end else if (En) begin
      pre_cnt <= tick_p0 ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Digit 0 is stepped by the tick; each higher digit by its neighbour's wrap.
  assign chain_p0[0] = step_go_p0;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .load      (Load),
      .d         (LoadVal[g*DIGIT_W +: DIGIT_W]),
      .step_in   (chain_p0[g]),
      .up        (Up),
      .q         (Q[g*DIGIT_W +: DIGIT_W]),
      .carry_out (chain_p0[g+1])
    );
  end

  // Stage p1: Step/Carry registered alongside the updated Q
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_p1  <= 1'b0;
      carry_p1 <= 1'b0;
    end else begin
      step_p1  <= step_go_p0;
      carry_p1 <= chain_p0[DIGITS];
    end
  end

  assign Step  = step_p1;
  assign Carry = carry_p1;

endmodule

// File: tb/tb_bcd_counter.sv
// Scoreboard bench: two counters (TICK_DIV=4 and TICK_DIV=1) share the
// same inputs; a decimal-arithmetic model predicts Q/Step/Carry per cycle.
module tb_bcd_counter;

  logic       Clock   = 1'b0;
  logic       Resetn  = 1'b0;
  logic       En      = 1'b0;
  logic       Up      = 1'b1;
  logic       Load    = 1'b0;
  logic [7:0] LoadVal = 8'h00;

  logic [7:0] q_slow, q_fast;
  logic       step_slow, step_fast, carry_slow, carry_fast;

  bcd_counter #(.DIGITS(2), .TICK_DIV(4), .PRE_W(3)) u_slow (
    .Clock(Clock), .Resetn(Resetn), .En(En), .Up(Up), .Load(Load),
    .LoadVal(LoadVal), .Q(q_slow), .Step(step_slow), .Carry(carry_slow)
  );

  bcd_counter #(.DIGITS(2), .TICK_DIV(1), .PRE_W(1)) u_fast (
    .Clock(Clock), .Resetn(Resetn), .En(En), .Up(Up), .Load(Load),
    .LoadVal(LoadVal), .Q(q_fast), .Step(step_fast), .Carry(carry_fast)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] q0;
    logic       s0;
    logic       c0;
    logic [7:0] q1;
    logic       s1;
    logic       c1;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Model state: count as a plain integer 0..99 and prescaler position.
  int mv[2]   = '{0, 0};
  int mpre[2] = '{0, 0};
  int td[2]   = '{4, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int san_val(input logic [7:0] lv);
    int hi, lo;
    hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic model_step(input int k, output logic s, output logic c);
    s = 1'b0;
    c = 1'b0;
    if (Load) begin
      mv[k]   = san_val(LoadVal);
      mpre[k] = 0;
    end else if (En) begin
      if (mpre[k] == td[k] - 1) begin
        mpre[k] = 0;
        s = 1'b1;
        if (Up) begin
          c     = (mv[k] == 99);
          mv[k] = (mv[k] + 1) % 100;
        end else begin
          c     = (mv[k] == 0);
          mv[k] = (mv[k] + 99) % 100;
        end
      end else begin
        mpre[k] = mpre[k] + 1;
      end
    end
  endtask

  // Entered at a negedge; drives one cycle, predicts its result, returns at next negedge.
  task automatic cyc(input logic en, input logic up, input logic ld, input logic [7:0] lv);
    exp_t e;
    logic s, c;
    En = en; Up = up; Load = ld; LoadVal = lv;
    model_step(0, s, c);
    e.q0 = to_bcd(mv[0]); e.s0 = s; e.c0 = c;
    model_step(1, s, c);
    e.q1 = to_bcd(mv[1]); e.s1 = s; e.c1 = c;
    sb.push_back(e);
    @(negedge Clock);
  endtask

  task automatic check_reset_state();
    check("rst_q_slow",     32'(q_slow),     32'h00);
    check("rst_step_slow",  32'(step_slow),  32'h0);
    check("rst_carry_slow", 32'(carry_slow), 32'h0);
    check("rst_q_fast",     32'(q_fast),     32'h00);
    check("rst_step_fast",  32'(step_fast),  32'h0);
    check("rst_carry_fast", 32'(carry_fast), 32'h0);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    #2 Resetn = 1'b0;
    #1 check_reset_state();
    @(negedge Clock);
    Resetn  = 1'b1;
    mv[0]   = 0; mv[1]   = 0;
    mpre[0] = 0; mpre[1] = 0;
  endtask

  // Monitor: one expected entry per clocked cycle, compared just after the edge.
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q_slow",     32'(q_slow),     32'(e.q0));
      check("step_slow",  32'(step_slow),  32'(e.s0));
      check("carry_slow", 32'(carry_slow), 32'(e.c0));
      check("q_fast",     32'(q_fast),     32'(e.q1));
      check("step_fast",  32'(step_fast),  32'(e.s1));
      check("carry_fast", 32'(carry_fast), 32'(e.c1));
    end
  end

  initial begin
    repeat (2) @(negedge Clock);
    check_reset_state();
    Resetn = 1'b1;

    // Pacing and hold: 6 En cycles, 5 idle, 2 more
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // Reset mid-count, then count from scratch
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    do_reset();
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // Up wrap through 99
    cyc(1'b1, 1'b1, 1'b1, 8'h98);
    repeat (9) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // Down borrow and down wrap from 00
    cyc(1'b1, 1'b0, 1'b1, 8'h10);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 8'h00);

    // Load priority/sanitising, held load, load with En=0
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'hF5);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 8'h3C);
    cyc(1'b0, 1'b1, 1'b1, 8'hAF);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Direction flip around 50
    cyc(1'b1, 1'b1, 1'b1, 8'h50);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 8'h00);

    // Randomised traffic with occasional loads and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 24) == 0), 8'($urandom));
      end
    end

    En = 1'b0; Load = 1'b0;
    @(negedge Clock);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
